xfft_cmult_pipe: RTL and testbench
==================================

// Module: xfft_cmult_pipe
// PURPOSE
//   Next-generation FFT twiddle complex multiplier. Computes (d_r + j*d_i)*(t_r +/- j*t_i)
//   per sample. Conjugate twiddle selectable per sample, so one instance serves FFT and IFFT.
//   Fixed 3-stage pipeline with full valid/ready backpressure, a user tag carried with each
//   sample, and saturation plus a sticky overflow flag.
//   Sits between the twiddle ROM / butterfly and the next FFT stage.
// PARAMETERS
//   NB_I   8   data input width, signed
//   NBF_I  7   data input fractional bits
//   NB_T   10  twiddle width, signed
//   NBF_T  9   twiddle fractional bits
//   NB_O   9   output width, signed
//   NBF_O  7   output fractional bits; legal range NBF_O <= NBF_I+NBF_T
//   NB_TAG 4   sideband tag width, >= 1
// PORTS
//   i_clk      in   1      clock, rising edge
//   i_rst_n    in   1      asynchronous reset, active low
//   i_valid    in   1      input sample valid
//   o_ready    out  1      block accepts the input sample this cycle
//   i_conj     in   1      1: use conj(twiddle) for this sample
//   i_tag      in   NB_TAG user tag, returned with the result
//   i_data_r   in   NB_I   data, real part
//   i_data_i   in   NB_I   data, imaginary part
//   i_tw_r     in   NB_T   twiddle, real part
//   i_tw_i     in   NB_T   twiddle, imaginary part
//   o_valid    out  1      output sample valid
//   i_ready    in   1      downstream accepts the output sample
//   o_data_r   out  NB_O   result, real part
//   o_data_i   out  NB_O   result, imaginary part
//   o_tag      out  NB_TAG tag belonging to o_data
//   o_ovf      out  1      sticky: a saturation has occurred
//   i_ovf_clr  in   1      synchronous clear of o_ovf
// BEHAVIOUR
//   - Reset: all stage valids, o_valid, o_data_r/i, o_tag and o_ovf are 0.
//     o_ready is 1 from the first cycle after reset release.
//   - Stage S1: registers the inputs. S2: registers the 4 products (NB_I+NB_T bits, signed).
//     S3: add/sub, round, saturate, then register onto the outputs.
//   - Latency: 3 cycles from accept to o_valid when unstalled. Throughput: 1 sample per cycle.
//   - Input transfer: i_valid & o_ready. Output transfer: o_valid & i_ready.
//   - Stage k loads when it is empty or its contents move on this cycle (bubble-collapsing).
//     S3 moves on when i_ready=1. o_ready is the S1 load condition, combinational from
//     i_ready and the stage valids.
//   - A stalled stage holds its data and tag unchanged. No sample is lost, duplicated or reordered.
//   - Adder is NB_I+NB_T+1 bits wide, with NBF_I+NBF_T fractional bits.
//     conj=0: re = dr*tr - di*ti, im = dr*ti + di*tr.
//     conj=1: re = dr*tr + di*ti, im = di*tr - dr*ti.
//   - Quantisation: drop D = NBF_I+NBF_T-NBF_O LSBs, rounding per CONFIGURATION.
//     Rounding is done 1 bit wider so the +half carry is never lost.
//   - Saturation: a result above 2^(NB_O-1)-1 clamps to that value; below -2^(NB_O-1) clamps
//     to that value. Each saturating part sets o_ovf on that sample's S3 load.
//   - o_ovf: cleared by i_ovf_clr. If a clear and a new overflow occur in the same cycle,
//     the set wins.
//   - Reset asserted mid-stream: all in-flight samples are discarded immediately (valids
//     cleared asynchronously). No partial sample appears after reset release.
// CONFIGURATION
//   XFFT_CMULT_ROUND_EN defined: round half-up. Add 2^(D-1) before the arithmetic
//     right-shift by D; when D=0 nothing is added.
//   XFFT_CMULT_ROUND_EN undefined: truncate (arithmetic shift by D, floor).
//     Saturation logic is still present.
//   All other behaviour is identical in both builds.
// TESTING (default parameters)
//   1 dr=8'h40, di=0, tr=10'h100, ti=0, conj=0 -> 3 cycles later re=9'h020, im=9'h000,
//     tag echoed, o_ovf=0.
//   2 dr=0, di=8'h40, tr=0, ti=10'h100: conj=0 -> re=9'h1E0, im=0; conj=1 -> re=9'h020, im=0.
//   3 dr=di=8'h80, tr=10'h200, ti=10'h1FF, conj=0 -> ROUND build: re=9'h0FF (saturated),
//     o_ovf=1, im=0. Truncate build: re=9'h0FF, o_ovf=0, im=0.
//   4 Stream tags 0..7 back to back, i_ready=0 for cycles 4-7 -> o_ready=0 once all 3 stages
//     are full; outputs are tags 0..7 in order with no gaps after i_ready returns high.
//   5 o_ovf=1, then i_ovf_clr pulse with no overflow -> o_ovf=0 next cycle.
//     Clear in the same cycle as a saturating S3 load -> o_ovf stays 1.
//   6 Assert i_rst_n=0 with 3 samples in flight -> o_valid=0 and o_ovf=0 immediately.
//     After release, no output until a new sample is accepted; o_ready=1.

Source files
------------

// File: rtl/xfft_cmult_pipe_if.sv
// ---------------------------------------------------------------------------
// xfft_cmult_pipe_if
//   Sample-stream bundle for the FFT twiddle complex multiplier.
//   The slave modport is the multiplier side; the master modport is the
//   producer/consumer side.
//   Input side  : i_valid/o_ready handshake, i_conj, i_tag, i_data_r/i,
//                 i_tw_r/i
//   Output side : o_valid/i_ready handshake, o_data_r/i, o_tag
//   Sideband    : o_ovf (sticky saturation flag), i_ovf_clr (clear)
// ---------------------------------------------------------------------------
interface xfft_cmult_pipe_if #(
  parameter int NB_I   = 8,
  parameter int NB_T   = 10,
  parameter int NB_O   = 9,
  parameter int NB_TAG = 4
);
  logic              i_valid;
  logic              o_ready;
  logic              i_conj;
  logic [NB_TAG-1:0] i_tag;
  logic [NB_I-1:0]   i_data_r;
  logic [NB_I-1:0]   i_data_i;
  logic [NB_T-1:0]   i_tw_r;
  logic [NB_T-1:0]   i_tw_i;
  logic              o_valid;
  logic              i_ready;
  logic [NB_O-1:0]   o_data_r;
  logic [NB_O-1:0]   o_data_i;
  logic [NB_TAG-1:0] o_tag;
  logic              o_ovf;
  logic              i_ovf_clr;

  modport slave (
    input  i_valid, i_conj, i_tag, i_data_r, i_data_i, i_tw_r, i_tw_i,
    input  i_ready, i_ovf_clr,
    output o_ready, o_valid, o_data_r, o_data_i, o_tag, o_ovf
  );

  modport master (
    output i_valid, i_conj, i_tag, i_data_r, i_data_i, i_tw_r, i_tw_i,
    output i_ready, i_ovf_clr,
    input  o_ready, o_valid, o_data_r, o_data_i, o_tag, o_ovf
  );
endinterface

// File: rtl/xfft_cmult_pipe.sv
// ---------------------------------------------------------------------------
// xfft_cmult_pipe
//   FFT twiddle complex multiplier: (d_r + j*d_i) * (t_r +/- j*t_i).
//   i_conj selects the conjugate twiddle per sample (FFT/IFFT sharing).
//   3-stage pipeline (S1 input regs, S2 products, S3 add/round/saturate)
//   with bubble-collapsing valid/ready backpressure, tag passthrough and a
//   sticky saturation flag.
//
//   Ports:
//     i_clk    rising-edge clock
//     i_rst_n  asynchronous active-low reset
//     s_if     xfft_cmult_pipe_if.slave: input/output handshakes, data,
//              tag, o_ovf / i_ovf_clr
//
//   Build option: define XFFT_CMULT_ROUND_EN for round half-up; otherwise
//   the dropped LSBs are truncated (floor). Saturation is present in both.
// ---------------------------------------------------------------------------
module xfft_cmult_pipe #(
  parameter int NB_I   = 8,
  parameter int NBF_I  = 7,
  parameter int NB_T   = 10,
  parameter int NBF_T  = 9,
  parameter int NB_O   = 9,
  parameter int NBF_O  = 7,
  parameter int NB_TAG = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  xfft_cmult_pipe_if.slave s_if
);

  localparam int NP = NB_I + NB_T;            // product width
  localparam int NS = NP + 1;                 // adder width
  localparam int NR = NS + 1;                 // rounding width
  localparam int D  = NBF_I + NBF_T - NBF_O;  // LSBs dropped

`ifdef XFFT_CMULT_ROUND_EN
  // 2^(D-1); evaluates to 0 when D == 0.
  localparam logic signed [NR-1:0] RND = signed'((NR'(1) << D) >> 1);
`else
  localparam logic signed [NR-1:0] RND = '0;
`endif
  localparam logic signed [NR-1:0] MAXV = NR'((1 << (NB_O - 1)) - 1);
  localparam logic signed [NR-1:0] MINV = ~MAXV;

  // Returns {saturated, value}.
  function automatic logic [NB_O:0] quant(input logic signed [NS-1:0] x);
    logic signed [NR-1:0] w;
    logic signed [NR-1:0] s;
    w = {x[NS-1], x};
    w = w + RND;
    s = w >>> D;
    if (s > MAXV)      return {1'b1, MAXV[NB_O-1:0]};
    else if (s < MINV) return {1'b1, MINV[NB_O-1:0]};
    else               return {1'b0, s[NB_O-1:0]};
  endfunction

  // Stage registers
  logic                    r_v1, r_v2, r_v3;
  logic signed [NB_I-1:0]  r_dr, r_di;
  logic signed [NB_T-1:0]  r_tr, r_ti;
  logic                    r_conj1, r_conj2;
  logic [NB_TAG-1:0]       r_tag1, r_tag2, r_tag3;
  logic signed [NP-1:0]    r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic [NB_O-1:0]         r_o_re, r_o_im;
  logic                    r_ovf;

  logic                    w_ld1, w_ld2, w_ld3;
  logic signed [NP-1:0]    w_dr_x, w_di_x, w_tr_x, w_ti_x;
  logic signed [NS-1:0]    w_rr_x, w_ii_x, w_ri_x, w_ir_x;
  logic signed [NS-1:0]    w_sum_re, w_sum_im;
  logic [NB_O:0]           w_q_re, w_q_im;

  // A stage loads when empty or when its occupant moves on this cycle.
  always_comb begin
    w_ld3 = ~r_v3 | s_if.i_ready;
    w_ld2 = ~r_v2 | w_ld3;
    w_ld1 = ~r_v1 | w_ld2;
  end

  always_comb begin
    w_dr_x = {{NB_T{r_dr[NB_I-1]}}, r_dr};
    w_di_x = {{NB_T{r_di[NB_I-1]}}, r_di};
    w_tr_x = {{NB_I{r_tr[NB_T-1]}}, r_tr};
    w_ti_x = {{NB_I{r_ti[NB_T-1]}}, r_ti};
  end

  always_comb begin
    w_rr_x   = {r_p_rr[NP-1], r_p_rr};
    w_ii_x   = {r_p_ii[NP-1], r_p_ii};
    w_ri_x   = {r_p_ri[NP-1], r_p_ri};
    w_ir_x   = {r_p_ir[NP-1], r_p_ir};
    w_sum_re = r_conj2 ? (w_rr_x + w_ii_x) : (w_rr_x - w_ii_x);
    w_sum_im = r_conj2 ? (w_ir_x - w_ri_x) : (w_ri_x + w_ir_x);
    w_q_re   = quant(w_sum_re);
    w_q_im   = quant(w_sum_im);
  end

  // S1: input registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1    <= 1'b0;
      r_dr    <= '0;
      r_di    <= '0;
      r_tr    <= '0;
      r_ti    <= '0;
      r_conj1 <= 1'b0;
      r_tag1  <= '0;
    end else if (w_ld1) begin
      r_v1    <= s_if.i_valid;
      r_dr    <= s_if.i_data_r;
      r_di    <= s_if.i_data_i;
      r_tr    <= s_if.i_tw_r;
      r_ti    <= s_if.i_tw_i;
      r_conj1 <= s_if.i_conj;
      r_tag1  <= s_if.i_tag;
    end
  end

  // S2: products
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v2    <= 1'b0;
      r_p_rr  <= '0;
      r_p_ii  <= '0;
      r_p_ri  <= '0;
      r_p_ir  <= '0;
      r_conj2 <= 1'b0;
      r_tag2  <= '0;
    end else if (w_ld2) begin
      r_v2    <= r_v1;
      r_p_rr  <= w_dr_x * w_tr_x;
      r_p_ii  <= w_di_x * w_ti_x;
      r_p_ri  <= w_dr_x * w_ti_x;
      r_p_ir  <= w_di_x * w_tr_x;
      r_conj2 <= r_conj1;
      r_tag2  <= r_tag1;
    end
  end

  // S3: quantised result onto the outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v3   <= 1'b0;
      r_o_re <= '0;
      r_o_im <= '0;
      r_tag3 <= '0;
    end else if (w_ld3) begin
      r_v3   <= r_v2;
      r_o_re <= w_q_re[NB_O-1:0];
      r_o_im <= w_q_im[NB_O-1:0];
      r_tag3 <= r_tag2;
    end
  end

  // Sticky overflow; a set in the same cycle as a clear takes priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ld3 && r_v2 && (w_q_re[NB_O] || w_q_im[NB_O])) begin
      r_ovf <= 1'b1;
    end else if (s_if.i_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign s_if.o_ready  = w_ld1;
  assign s_if.o_valid  = r_v3;
  assign s_if.o_data_r = r_o_re;
  assign s_if.o_data_i = r_o_im;
  assign s_if.o_tag    = r_tag3;
  assign s_if.o_ovf    = r_ovf;

endmodule

// File: tb/tb_xfft_cmult_pipe.sv
`timescale 1ns/1ps
module tb_xfft_cmult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xfft_cmult_pipe_if #(.NB_I(8), .NB_T(10), .NB_O(9), .NB_TAG(4)) bus ();

  xfft_cmult_pipe #(
    .NB_I(8), .NBF_I(7), .NB_T(10), .NBF_T(9),
    .NB_O(9), .NBF_O(7), .NB_TAG(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .s_if   (bus)
  );

`ifdef XFFT_CMULT_ROUND_EN
  localparam logic [8:0] F_RE  = 9'h001;
  localparam logic [8:0] H_RE  = 9'h000;
  localparam logic       D_OVF = 1'b1;
`else
  localparam logic [8:0] F_RE  = 9'h000;
  localparam logic [8:0] H_RE  = 9'h1FF;
  localparam logic       D_OVF = 1'b0;
`endif

  typedef struct {
    logic [7:0] dr, di;
    logic [9:0] tr, ti;
    logic       cj;
    logic [8:0] re, im;
  } vec_t;

  typedef struct {
    logic [8:0] re, im;
    logic [3:0] tag;
  } exp_t;

  vec_t vt [11];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int v, input logic [3:0] tag);
    int n;
    n = 0;
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_data_r = vt[v].dr;
    bus.i_data_i = vt[v].di;
    bus.i_tw_r   = vt[v].tr;
    bus.i_tw_i   = vt[v].ti;
    bus.i_conj   = vt[v].cj;
    bus.i_tag    = tag;
    #1;
    while (!bus.o_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.o_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got o_ready=0 expected 1 within 50 cycles");
    end else begin
      sbq.push_back('{vt[v].re, vt[v].im, tag});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", sbq.size(), 0);
  endtask

  task automatic ovf_clear_pulse();
    @(negedge clk);
    bus.i_ovf_clr = 1'b1;
    @(negedge clk);
    bus.i_ovf_clr = 1'b0;
    #1;
    chk("ovf_after_clr", bus.o_ovf, 0);
  endtask

  // Output monitor: compares every output transfer against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.o_valid && bus.i_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got tag %0h expected no output", bus.o_tag);
        end else begin
          e = sbq.pop_front();
          chk("out_re",  bus.o_data_r, e.re);
          chk("out_im",  bus.o_data_i, e.im);
          chk("out_tag", bus.o_tag,    e.tag);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    vt[0]  = '{8'h40, 8'h00, 10'h100, 10'h000, 1'b0, 9'h020, 9'h000};
    vt[1]  = '{8'h00, 8'h40, 10'h000, 10'h100, 1'b0, 9'h1E0, 9'h000};
    vt[2]  = '{8'h00, 8'h40, 10'h000, 10'h100, 1'b1, 9'h020, 9'h000};
    vt[3]  = '{8'h80, 8'h80, 10'h1FF, 10'h200, 1'b0, 9'h100, 9'h000};
    vt[4]  = '{8'h01, 8'h00, 10'h100, 10'h000, 1'b0, F_RE,   9'h000};
    vt[5]  = '{8'h01, 8'h00, 10'h0FF, 10'h000, 1'b0, 9'h000, 9'h000};
    vt[6]  = '{8'hFF, 8'h00, 10'h100, 10'h000, 1'b0, H_RE,   9'h000};
    vt[7]  = '{8'h20, 8'h10, 10'h080, 10'h040, 1'b0, 9'h006, 9'h008};
    vt[8]  = '{8'h20, 8'h10, 10'h080, 10'h040, 1'b1, 9'h00A, 9'h000};
    vt[9]  = '{8'h80, 8'h80, 10'h200, 10'h1FF, 1'b0, 9'h0FF, 9'h000};
    vt[10] = '{8'h80, 8'h80, 10'h200, 10'h200, 1'b1, 9'h0FF, 9'h000};

    bus.i_valid   = 1'b0;
    bus.i_conj    = 1'b0;
    bus.i_tag     = '0;
    bus.i_data_r  = '0;
    bus.i_data_i  = '0;
    bus.i_tw_r    = '0;
    bus.i_tw_i    = '0;
    bus.i_ready   = 1'b1;
    bus.i_ovf_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_o_valid", bus.o_valid,  0);
    chk("rst_o_ovf",   bus.o_ovf,    0);
    chk("rst_o_re",    bus.o_data_r, 0);
    chk("rst_o_im",    bus.o_data_i, 0);
    chk("rst_o_tag",   bus.o_tag,    0);
    rst_n = 1'b1;
    #1;
    chk("rst_o_ready", bus.o_ready, 1);

    // Directed arithmetic vectors, back to back
    for (int v = 0; v < 9; v++) send(v, 4'(v));
    idle();
    drain();
    chk("ovf_no_sat", bus.o_ovf, 0);

    // Near-full-scale: saturates only when rounding pushes it over
    send(9, 4'h9);
    idle();
    drain();
    chk("ovf_vec_d", bus.o_ovf, D_OVF);
    ovf_clear_pulse();

    // Saturation in both builds, then clear
    send(10, 4'hA);
    idle();
    drain();
    chk("ovf_set", bus.o_ovf, 1);
    ovf_clear_pulse();

    // Clear coinciding with a saturating S3 load: set wins
    send(10, 4'hB);
    idle();
    @(negedge clk);
    bus.i_ovf_clr = 1'b1;
    @(negedge clk);
    bus.i_ovf_clr = 1'b0;
    #1;
    chk("ovf_set_wins", bus.o_ovf, 1);
    drain();
    ovf_clear_pulse();

    // Streaming tags 0..7 with downstream stall for cycles 4..7
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.i_ready = !(cyc >= 4 && cyc <= 7);
      if (idx < 8) begin
        bus.i_valid  = 1'b1;
        bus.i_data_r = vt[idx[0] ? 7 : 0].dr;
        bus.i_data_i = vt[idx[0] ? 7 : 0].di;
        bus.i_tw_r   = vt[idx[0] ? 7 : 0].tr;
        bus.i_tw_i   = vt[idx[0] ? 7 : 0].ti;
        bus.i_conj   = vt[idx[0] ? 7 : 0].cj;
        bus.i_tag    = 4'(idx);
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (cyc == 5) chk("stall_o_ready", bus.o_ready, 0);
      if (cyc == 7) chk("stall_tag_hold", bus.o_tag, 1);
      if (cyc >= 8 && cyc <= 14) chk("stream_no_gap", bus.o_valid, 1);
      if (bus.i_valid && bus.o_ready) begin
        sbq.push_back('{vt[idx[0] ? 7 : 0].re, vt[idx[0] ? 7 : 0].im, 4'(idx)});
        idx++;
      end
    end
    chk("stream_all_accepted", idx, 8);
    drain();

    // Reset with three samples in flight
    send(10, 4'hC);
    send(0,  4'hD);
    send(5,  4'hE);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    #1;
    chk("pre_rst_valid", bus.o_valid, 1);
    chk("pre_rst_ovf",   bus.o_ovf,   1);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("async_rst_valid", bus.o_valid, 0);
    chk("async_rst_ovf",   bus.o_ovf,   0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    #1;
    chk("post_rst_ready", bus.o_ready, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_out", bus.o_valid, 0);
    end
    send(8, 4'hF);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
